// File: rtl/switch_debounce.sv
// Eight-channel slide-switch debouncer: two-flop synchronizer, per-bit stability
// counter, clean level output plus one-cycle rise/fall pulses.
module switch_debounce #(
    parameter int unsigned CNT_MAX = 100000,
    parameter int unsigned CNT_W   = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] switch_raw,
    output logic [7:0] switch,
    output logic [7:0] rise,
    output logic [7:0] fall,
    output logic       changed
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [7:0]       s1;
    logic [7:0]       s2;
    logic [CNT_W-1:0] cnt [8];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 8'h00;
            s2     <= 8'h00;
            switch <= 8'h00;
            rise   <= 8'h00;
            fall   <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1   <= switch_raw;
            s2   <= s1;
            rise <= 8'h00;
            fall <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                if (s2[i] == switch[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] < CNT_LAST) begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end else begin
                    // Stable long enough: commit the new level and pulse its edge.
                    switch[i] <= s2[i];
                    rise[i]   <= s2[i];
                    fall[i]   <= ~s2[i];
                    cnt[i]    <= '0;
                end
            end
        end
    end

    always_comb begin
        changed = |(rise | fall);
    end

    a_no_rise_and_fall: assert property (@(posedge clk) (rise & fall) == 8'h00);

    for (genvar g = 0; g < 8; g++) begin : g_cnt_chk
        a_cnt_bound: assert property (@(posedge clk) cnt[g] <= CNT_LAST);
    end

endmodule

// File: tb/tb_switch_debounce.sv
// Directed vector table, hand-written reset/glitch sequences, and a random bounce
// run against a behavioural model of the debouncer (CNT_MAX = 4).
module tb_switch_debounce;

    localparam int unsigned CNT_MAX = 4;
    localparam int unsigned CNT_W   = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] switch_raw;
    logic [7:0] switch;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       changed;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst;
        logic [7:0] raw;
        logic [7:0] sw;
        logic [7:0] ri;
        logic [7:0] fa;
    } vec_t;

    vec_t tbl[$];

    switch_debounce #(
        .CNT_MAX(CNT_MAX),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .switch_raw(switch_raw),
        .switch    (switch),
        .rise      (rise),
        .fall      (fall),
        .changed   (changed)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic [7:0] raw);
        rst        = r;
        switch_raw = raw;
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string nm, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic check_out(input string nm, input logic [7:0] sw, input logic [7:0] ri,
                             input logic [7:0] fa);
        logic exp_ch;
        exp_ch = |(ri | fa);
        check8({nm, ".switch"}, switch, sw);
        check8({nm, ".rise"}, rise, ri);
        check8({nm, ".fall"}, fall, fa);
        total++;
        if (changed !== exp_ch) begin
            bad++;
            $display("FAIL %s.changed: got %b want %b", nm, changed, exp_ch);
        end
    endtask

    function automatic void add_n(input int n, input logic r, input logic [7:0] raw,
                                  input logic [7:0] sw, input logic [7:0] ri,
                                  input logic [7:0] fa);
        vec_t v;
        v.rst = r;
        v.raw = raw;
        v.sw  = sw;
        v.ri  = ri;
        v.fa  = fa;
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endfunction

    // Behavioural model state
    logic [7:0] m_s1, m_s2, m_sw, m_ri, m_fa;
    int         m_run [8];

    task automatic model_edge(input logic r, input logic [7:0] raw);
        if (r) begin
            m_s1 = 8'h00; m_s2 = 8'h00; m_sw = 8'h00; m_ri = 8'h00; m_fa = 8'h00;
            for (int b = 0; b < 8; b++) m_run[b] = 0;
        end else begin
            m_ri = 8'h00;
            m_fa = 8'h00;
            for (int b = 0; b < 8; b++) begin
                if (m_s2[b] != m_sw[b]) begin
                    m_run[b] = m_run[b] + 1;
                    if (m_run[b] == CNT_MAX) begin
                        m_sw[b]  = m_s2[b];
                        m_ri[b]  = m_s2[b];
                        m_fa[b]  = ~m_s2[b];
                        m_run[b] = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = raw;
        end
    endtask

    initial begin
        logic [7:0] raw;
        logic       r;

        rst        = 1'b1;
        switch_raw = 8'h00;

        // Single-bit rise: edge 6 after change
        add_n(2, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
        add_n(5, 1'b0, 8'h01, 8'h00, 8'h00, 8'h00);
        add_n(1, 1'b0, 8'h01, 8'h01, 8'h01, 8'h00);
        add_n(1, 1'b0, 8'h01, 8'h01, 8'h00, 8'h00);
        // Bit 3 glitch for 3 cycles: no change
        add_n(3, 1'b0, 8'h09, 8'h01, 8'h00, 8'h00);
        add_n(3, 1'b0, 8'h01, 8'h01, 8'h00, 8'h00);
        // All high, then all low
        add_n(5, 1'b0, 8'hFF, 8'h01, 8'h00, 8'h00);
        add_n(1, 1'b0, 8'hFF, 8'hFF, 8'hFE, 8'h00);
        add_n(1, 1'b0, 8'hFF, 8'hFF, 8'h00, 8'h00);
        add_n(5, 1'b0, 8'h00, 8'hFF, 8'h00, 8'h00);
        add_n(1, 1'b0, 8'h00, 8'h00, 8'h00, 8'hFF);
        add_n(1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        // Input held high through reset release
        add_n(2, 1'b1, 8'hA5, 8'h00, 8'h00, 8'h00);
        add_n(5, 1'b0, 8'hA5, 8'h00, 8'h00, 8'h00);
        add_n(1, 1'b0, 8'hA5, 8'hA5, 8'hA5, 8'h00);
        add_n(1, 1'b0, 8'hA5, 8'hA5, 8'h00, 8'h00);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].raw);
            check_out($sformatf("row%0d", i), tbl[i].sw, tbl[i].ri, tbl[i].fa);
        end

        // Glitch on bit 1 from a stable A5: counter must clear, outputs unchanged
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'hA7);
            check_out($sformatf("glitch_hi%0d", i), 8'hA5, 8'h00, 8'h00);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'hA5);
            check_out($sformatf("glitch_lo%0d", i), 8'hA5, 8'h00, 8'h00);
        end
        check8("glitch_cnt1", 8'(dut.cnt[1]), 8'h00);

        // Reset on edge 4 of a count, then full recount
        step(1'b1, 8'h00);
        step(1'b1, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h01);
            check_out($sformatf("midrst_pre%0d", i), 8'h00, 8'h00, 8'h00);
        end
        step(1'b1, 8'h01);
        check_out("midrst_edge", 8'h00, 8'h00, 8'h00);
        check8("midrst_cnt0", 8'(dut.cnt[0]), 8'h00);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h01);
            check_out($sformatf("midrst_re%0d", i), 8'h00, 8'h00, 8'h00);
        end
        step(1'b0, 8'h01);
        check_out("midrst_done", 8'h01, 8'h01, 8'h00);

        // Reset on the completing edge suppresses update and pulse
        step(1'b1, 8'h00);
        step(1'b1, 8'h00);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h10);
        check_out("cmplrst_pre", 8'h00, 8'h00, 8'h00);
        step(1'b1, 8'h10);
        check_out("cmplrst_edge", 8'h00, 8'h00, 8'h00);
        step(1'b0, 8'h00);
        check_out("cmplrst_after", 8'h00, 8'h00, 8'h00);

        // Random bounce against the model
        model_edge(1'b1, 8'h00);
        step(1'b1, 8'h00);
        raw = 8'h00;
        for (int c = 0; c < 20000; c++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(7) == 0) raw[b] = ~raw[b];
            end
            r = ($urandom_range(499) == 0);
            model_edge(r, raw);
            step(r, raw);
            check_out($sformatf("rnd%0d", c), m_sw, m_ri, m_fa);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
